// File: rtl/alu_pkg.sv
// Shared encodings for the 16-bit processor ALU:
// opcodes, function codes, condition codes and PSR bit positions.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_REG   = 4'h0,
        OP_ANDI  = 4'h1,
        OP_ORI   = 4'h2,
        OP_XORI  = 4'h3,
        OP_SPEC  = 4'h4,
        OP_ADDI  = 4'h5,
        OP_ADDUI = 4'h6,
        OP_ADDCI = 4'h7,
        OP_SHIFT = 4'h8,
        OP_SUBI  = 4'h9,
        OP_SUBCI = 4'hA,
        OP_CMPI  = 4'hB,
        OP_BCOND = 4'hC,
        OP_MOVI  = 4'hD,
        OP_MULI  = 4'hE,
        OP_LUI   = 4'hF
    } opcode_e;

    localparam logic [3:0] F_AND  = 4'h1;
    localparam logic [3:0] F_OR   = 4'h2;
    localparam logic [3:0] F_XOR  = 4'h3;
    localparam logic [3:0] F_NOT  = 4'h4;
    localparam logic [3:0] F_ADD  = 4'h5;
    localparam logic [3:0] F_ADDU = 4'h6;
    localparam logic [3:0] F_ADDC = 4'h7;
    localparam logic [3:0] F_SUB  = 4'h9;
    localparam logic [3:0] F_SUBC = 4'hA;
    localparam logic [3:0] F_CMP  = 4'hB;
    localparam logic [3:0] F_MOV  = 4'hD;
    localparam logic [3:0] F_MUL  = 4'hE;
    localparam logic [3:0] F_TEST = 4'hF;

    localparam logic [3:0] F_JAL   = 4'h8;
    localparam logic [3:0] F_JCOND = 4'hC;
    localparam logic [3:0] F_SCOND = 4'hD;

    localparam logic [3:0] F_LSHI_L  = 4'h0;
    localparam logic [3:0] F_LSHI_R  = 4'h1;
    localparam logic [3:0] F_ASHUI_L = 4'h2;
    localparam logic [3:0] F_ASHUI_R = 4'h3;
    localparam logic [3:0] F_LSH     = 4'h4;
    localparam logic [3:0] F_ASHU    = 4'h6;

    typedef enum logic [3:0] {
        C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3,
        C_HI = 4'h4, C_LS = 4'h5, C_GT = 4'h6, C_LE = 4'h7,
        C_FS = 4'h8, C_FC = 4'h9, C_LO = 4'hA, C_HS = 4'hB,
        C_LT = 4'hC, C_GE = 4'hD, C_UC = 4'hE, C_NV = 4'hF
    } cond_e;

    localparam int PSR_C = 4;
    localparam int PSR_L = 3;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 1;
    localparam int PSR_N = 0;

endpackage

// File: rtl/proc_alu_if.sv
// Operand/opcode/flag bundle between the datapath and the ALU.
// PSR vectors are ordered {C,L,F,Z,N}.
interface proc_alu_if;

    logic [15:0] dst;
    logic [15:0] src;
    logic [3:0]  oper;
    logic [3:0]  func;
    logic [3:0]  cond;
    logic [4:0]  psrRead;
    logic [15:0] result;
    logic [4:0]  psrWrite;
    logic [4:0]  psrWrEn;

    modport master (
        output dst, src, oper, func, cond, psrRead,
        input  result, psrWrite, psrWrEn
    );

    modport slave (
        input  dst, src, oper, func, cond, psrRead,
        output result, psrWrite, psrWrEn
    );

endinterface

// File: rtl/alu_cond_eval.sv
// Evaluates a 4-bit condition code against the current PSR flags.
module alu_cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] psr,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        unique case (cond_e'(cond))
            C_EQ: taken = psr[PSR_Z];
            C_NE: taken = !psr[PSR_Z];
            C_CS: taken = psr[PSR_C];
            C_CC: taken = !psr[PSR_C];
            C_HI: taken = psr[PSR_L];
            C_LS: taken = !psr[PSR_L];
            C_GT: taken = psr[PSR_N];
            C_LE: taken = !psr[PSR_N];
            C_FS: taken = psr[PSR_F];
            C_FC: taken = !psr[PSR_F];
            C_LO: taken = !psr[PSR_L] && !psr[PSR_Z];
            C_HS: taken = psr[PSR_L] || psr[PSR_Z];
            C_LT: taken = !psr[PSR_N] && !psr[PSR_Z];
            C_GE: taken = psr[PSR_N] || psr[PSR_Z];
            C_UC: taken = 1'b1;
            C_NV: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/proc_alu.sv
// 16-bit datapath ALU with one registered output stage.
// ALU_MUL_EN builds the multiplier; otherwise MUL/MULI return zero.
module proc_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    proc_alu_if.slave bus
);

    logic [WIDTH-1:0] dst;
    logic [WIDTH-1:0] src;
    opcode_e          op;
    logic [3:0]       fn;
    logic             taken;

    assign dst = bus.dst;
    assign src = bus.src;
    assign op  = opcode_e'(bus.oper);
    assign fn  = bus.func;

    alu_cond_eval u_cond (
        .cond  (bus.cond),
        .psr   (bus.psrRead),
        .taken (taken)
    );

    logic reg_op, add_cls, sub_cls, cmp_cls, use_cin, z_en, cin;

    always_comb begin
        reg_op  = (op == OP_REG);
        add_cls = (op == OP_ADDI) || (op == OP_ADDCI) ||
                  (reg_op && (fn == F_ADD || fn == F_ADDC));
        sub_cls = (op == OP_SUBI) || (op == OP_SUBCI) ||
                  (reg_op && (fn == F_SUB || fn == F_SUBC));
        cmp_cls = (op == OP_CMPI) || (reg_op && fn == F_CMP);
        use_cin = (op == OP_ADDCI) || (op == OP_SUBCI) ||
                  (reg_op && (fn == F_ADDC || fn == F_SUBC));
        z_en    = add_cls || sub_cls || cmp_cls ||
                  (op inside {OP_ANDI, OP_ORI, OP_XORI}) ||
                  (reg_op && (fn inside {F_AND, F_OR, F_XOR,
                                         F_NOT, F_TEST}));
        cin     = use_cin && bus.psrRead[PSR_C];
    end

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, dst} + {1'b0, src} + {{WIDTH{1'b0}}, cin};
    assign diff = {1'b0, dst} - {1'b0, src} - {{WIDTH{1'b0}}, cin};

    // Right shifts take the negated 5-bit amount; >=16 fully drains.
    logic [4:0]       amt;
    logic [WIDTH-1:0] shl, shr, sar, mul;

    assign amt = 5'd0 - src[4:0];
    assign shl = dst << src[3:0];
    assign shr = dst >> amt;
    assign sar = $unsigned($signed(dst) >>> amt);

`ifdef ALU_MUL_EN
    assign mul = dst * src;
`else
    assign mul = '0;
`endif

    logic [WIDTH-1:0] res;

    always_comb begin
        res = sum[WIDTH-1:0];
        unique case (op)
            OP_REG: begin
                case (fn)
                    F_AND, F_TEST:        res = dst & src;
                    F_OR:                 res = dst | src;
                    F_XOR:                res = dst ^ src;
                    F_NOT:                res = ~dst;
                    F_SUB, F_SUBC, F_CMP: res = diff[WIDTH-1:0];
                    F_MOV:                res = src;
                    F_MUL:                res = mul;
                    default:              res = sum[WIDTH-1:0];
                endcase
            end
            OP_ANDI: res = dst & src;
            OP_ORI:  res = dst | src;
            OP_XORI: res = dst ^ src;
            OP_SPEC: begin
                case (fn)
                    F_JAL:   res = src;
                    F_JCOND: res = taken ? src : dst;
                    F_SCOND: res = {{(WIDTH-1){1'b0}}, taken};
                    default: res = sum[WIDTH-1:0];
                endcase
            end
            OP_ADDI, OP_ADDUI, OP_ADDCI: res = sum[WIDTH-1:0];
            OP_SHIFT: begin
                case (fn)
                    F_LSHI_L, F_ASHUI_L: res = shl;
                    F_LSHI_R:            res = shr;
                    F_ASHUI_R:           res = sar;
                    F_LSH:               res = src[WIDTH-1] ? shr : shl;
                    F_ASHU:              res = src[WIDTH-1] ? sar : shl;
                    default:             res = sum[WIDTH-1:0];
                endcase
            end
            OP_SUBI, OP_SUBCI, OP_CMPI: res = diff[WIDTH-1:0];
            OP_BCOND: res = taken ? sum[WIDTH-1:0] : dst;
            OP_MOVI:  res = src;
            OP_MULI:  res = mul;
            OP_LUI:   res = {src[7:0], dst[7:0]};
        endcase
    end

    logic ovf_add, ovf_sub, c_nxt, f_nxt;
    logic [4:0] psr_nxt, en_nxt;

    always_comb begin
        ovf_add = (dst[WIDTH-1] == src[WIDTH-1]) &&
                  (sum[WIDTH-1] != dst[WIDTH-1]);
        ovf_sub = (dst[WIDTH-1] != src[WIDTH-1]) &&
                  (diff[WIDTH-1] != dst[WIDTH-1]);
        c_nxt   = add_cls ? sum[WIDTH] :
                  sub_cls ? diff[WIDTH] : 1'b0;
        f_nxt   = add_cls ? ovf_add :
                  (sub_cls || cmp_cls) ? ovf_sub : 1'b0;
        psr_nxt = {c_nxt, (dst < src), f_nxt,
                   (res == '0), res[WIDTH-1]};
        en_nxt  = {add_cls || sub_cls, cmp_cls, add_cls || sub_cls,
                   z_en, add_cls || sub_cls || cmp_cls};
    end

    logic [WIDTH-1:0] result_q;
    logic [4:0]       psr_q, en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            psr_q    <= '0;
            en_q     <= '0;
        end else begin
            result_q <= res;
            psr_q    <= psr_nxt;
            en_q     <= en_nxt;
        end
    end

    assign bus.result   = result_q;
    assign bus.psrWrite = psr_q;
    assign bus.psrWrEn  = en_q;

endmodule

// File: tb/tb_proc_alu.sv
// Directed and random checks of proc_alu against an arithmetic model.
module tb_proc_alu;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    proc_alu_if bus ();

    proc_alu #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit cond_ok(input logic [3:0] cd, input logic [4:0] p);
        bit c, l, f, z, n;
        {c, l, f, z, n} = p;
        case (cd)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return l;
            4'h5: return !l;
            4'h6: return n;
            4'h7: return !n;
            4'h8: return f;
            4'h9: return !f;
            4'hA: return !l && !z;
            4'hB: return l || z;
            4'hC: return !n && !z;
            4'hD: return n || z;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [25:0] model(
        input logic [3:0] op, fn, cd, input logic [4:0] p,
        input logic [15:0] d, s);
        int ud, us, sd, ss, r, sr, ci, amt, mr;
        bit t, ca, cs, cc, zen, cf, ff;
        logic [15:0] res;
        ud = int'(d); us = int'(s);
        sd = int'($signed(d)); ss = int'($signed(s));
        t = cond_ok(cd, p);
        amt = (32 - int'(s[4:0])) % 32;
`ifdef ALU_MUL_EN
        mr = ud * us;
`else
        mr = 0;
`endif
        r = ud + us; ci = 0;
        ca = 0; cs = 0; cc = 0; zen = 0; cf = 0; ff = 0;
        case (op)
            4'h0: case (fn)
                4'h1, 4'hF: begin r = ud & us; zen = 1; end
                4'h2: begin r = ud | us; zen = 1; end
                4'h3: begin r = ud ^ us; zen = 1; end
                4'h4: begin r = ~ud; zen = 1; end
                4'h5: ca = 1;
                4'h7: begin ca = 1; ci = int'(p[4]); end
                4'h9: cs = 1;
                4'hA: begin cs = 1; ci = int'(p[4]); end
                4'hB: cc = 1;
                4'hD: r = us;
                4'hE: r = mr;
                default: r = ud + us;
            endcase
            4'h1: begin r = ud & us; zen = 1; end
            4'h2: begin r = ud | us; zen = 1; end
            4'h3: begin r = ud ^ us; zen = 1; end
            4'h4: case (fn)
                4'h8: r = us;
                4'hC: r = t ? us : ud;
                4'hD: r = int'(t);
                default: r = ud + us;
            endcase
            4'h5: ca = 1;
            4'h7: begin ca = 1; ci = int'(p[4]); end
            4'h8: case (fn)
                4'h0, 4'h2: r = ud << s[3:0];
                4'h1: r = ud >> amt;
                4'h3: r = sd >>> amt;
                4'h4: r = s[15] ? (ud >> amt) : (ud << s[3:0]);
                4'h6: r = s[15] ? (sd >>> amt) : (ud << s[3:0]);
                default: r = ud + us;
            endcase
            4'h9: cs = 1;
            4'hA: begin cs = 1; ci = int'(p[4]); end
            4'hB: cc = 1;
            4'hC: r = t ? ud + us : ud;
            4'hD: r = us;
            4'hE: r = mr;
            4'hF: r = (us % 256) * 256 + (ud % 256);
            default: r = ud + us;
        endcase
        if (ca) begin
            r = ud + us + ci;
            cf = (r > 65535);
            sr = sd + ss + ci;
            ff = (sr > 32767) || (sr < -32768);
        end
        if (cs || cc) begin
            r = ud - us - ci;
            cf = cs && (r < 0);
            sr = sd - ss - ci;
            ff = (sr > 32767) || (sr < -32768);
        end
        res = r[15:0];
        return {res,
                cf, (ud < us), ff, (res == 16'h0), res[15],
                ca || cs, cc, ca || cs, zen || ca || cs || cc, ca || cs || cc};
    endfunction

    task automatic chk(input string tag, input logic [25:0] obs, input logic [25:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h (result/psrWrite/psrWrEn)", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, fn, cd, input logic [4:0] p,
                         input logic [15:0] d, s);
        @(negedge clk);
        bus.oper = op; bus.func = fn; bus.cond = cd;
        bus.psrRead = p; bus.dst = d; bus.src = s;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [25:0] obs_now();
        return {bus.result, bus.psrWrite, bus.psrWrEn};
    endfunction

    function automatic logic [15:0] pick();
        logic [15:0] corner [4];
        corner = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
        if ($urandom_range(3) == 0) return corner[$urandom_range(3)];
        return 16'($urandom);
    endfunction

    initial begin
        logic [3:0] op, fn, cd;
        logic [4:0] p;
        logic [15:0] d, s;
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0;
        bus.oper = 4'h0; bus.func = 4'h5; bus.cond = 4'h0;
        bus.psrRead = 5'h0; bus.dst = 16'h1234; bus.src = 16'h1111;
        repeat (2) @(posedge clk);
        #1 chk("reset_state", obs_now(), 26'h0);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("after_release", obs_now(), 26'h0);

        drive(4'h0, 4'h5, 4'h0, 5'b00000, 16'h7FFF, 16'h0001);
        chk("add_ovf", obs_now(), {16'h8000, 5'b00101, 5'b10111});
        drive(4'h0, 4'hA, 4'h0, 5'b10000, 16'h0005, 16'h0005);
        chk("subc_borrow", obs_now(), {16'hFFFF, 5'b10001, 5'b10111});
        drive(4'hB, 4'h0, 4'h0, 5'b00000, 16'h0003, 16'h0005);
        chk("cmpi_lt", obs_now(), {16'hFFFE, 5'b01001, 5'b01011});
        drive(4'h8, 4'h1, 4'h0, 5'b00000, 16'h8000, 16'h001F);
        chk("lshi_r", obs_now(), {16'h4000, 5'b00000, 5'b00000});
        drive(4'h8, 4'h3, 4'h0, 5'b00000, 16'h8000, 16'h001F);
        chk("ashui_r", obs_now(), {16'hC000, 5'b00001, 5'b00000});
        drive(4'h8, 4'h4, 4'h0, 5'b00000, 16'h0001, 16'h0004);
        chk("lsh_left", obs_now(), {16'h0010, 5'b01000, 5'b00000});
        drive(4'h8, 4'h1, 4'h0, 5'b00000, 16'h8000, 16'h0010);
        chk("lshi_r_drain", obs_now(), {16'h0000, 5'b00010, 5'b00000});
        drive(4'h8, 4'h3, 4'h0, 5'b00000, 16'h8000, 16'h0010);
        chk("ashui_r_fill", obs_now(), {16'hFFFF, 5'b00001, 5'b00000});
        drive(4'h4, 4'hD, 4'h0, 5'b00010, 16'h0000, 16'h0000);
        chk("scond_eq", obs_now(), {16'h0001, 5'b00000, 5'b00000});
        drive(4'hC, 4'h0, 4'hF, 5'b11111, 16'h1234, 16'h0010);
        chk("bcond_never", obs_now(), {16'h1234, 5'b00000, 5'b00000});
        drive(4'hC, 4'h0, 4'hE, 5'b00000, 16'h1234, 16'h0010);
        chk("bcond_always", obs_now(), {16'h1244, 5'b00000, 5'b00000});
        drive(4'h4, 4'hC, 4'hE, 5'b00000, 16'h0000, 16'hABCD);
        chk("jcond_always", obs_now(), {16'hABCD, 5'b01001, 5'b00000});
        drive(4'hE, 4'h0, 4'h0, 5'b00000, 16'h0100, 16'h0100);
        chk("muli_wrap", obs_now(), {16'h0000, 5'b00010, 5'b00000});
        drive(4'h6, 4'h0, 4'h0, 5'b00000, 16'hFFFF, 16'h0001);
        chk("addui_noflags", obs_now(), {16'h0000, 5'b00010, 5'b00000});
        drive(4'hF, 4'h0, 4'h0, 5'b00000, 16'h00CD, 16'h00AB);
        chk("lui", obs_now(), {16'hABCD, 5'b00001, 5'b00000});

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("reset_async", obs_now(), 26'h0);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("reset_hold", obs_now(), 26'h0);
        @(posedge clk);
        #1 chk("first_after_reset", obs_now(), {16'hABCD, 5'b00001, 5'b00000});

        for (int i = 0; i < 600; i++) begin
            op = 4'($urandom); fn = 4'($urandom); cd = 4'($urandom);
            p = 5'($urandom); d = pick(); s = pick();
            drive(op, fn, cd, p, d, s);
            chk($sformatf("rand%0d_op%h_fn%h", i, op, fn), obs_now(),
                model(op, fn, cd, p, d, s));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
